// File: rtl/dll_pkg.sv
// ---------------------------------------------------------------------------
// dll_pkg
// Shared definitions for the Data Link Layer transmit path: the LCRC-32
// constants, the sequence-number width and the framer state encoding.
// ---------------------------------------------------------------------------
package dll_pkg;

    localparam logic [31:0] LCRC_POLY   = 32'hEDB8_8320;  // reflected CRC-32
    localparam logic [31:0] LCRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] LCRC_XOROUT = 32'hFFFF_FFFF;

    localparam int SEQ_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        BODY,
        TAIL
    } framer_state_t;

    // The LCRC goes onto the wire low byte first; this returns it as a
    // 32-bit field in stream order (first byte in the MSBs).
    function automatic logic [31:0] lcrc_byte_order(input logic [31:0] crc);
        return {crc[7:0], crc[15:8], crc[23:16], crc[31:24]};
    endfunction

endpackage

// File: rtl/lcrc32_step.sv
// ---------------------------------------------------------------------------
// lcrc32_step
// Combinational LCRC-32 update over a variable number of bytes.
//   crc_in  : running CRC register (not yet final-XORed)
//   data    : DATA_W bits, first byte in the MSBs
//   nbytes  : number of leading bytes of data to fold in (0..DATA_W/8)
//   crc_out : updated CRC register
// Each byte is consumed LSB-first, as the reflected CRC-32 requires.
// ---------------------------------------------------------------------------
module lcrc32_step
    import dll_pkg::*;
#(
    parameter  int DATA_W = 64,
    localparam int BYTES  = DATA_W / 8,
    localparam int CNT_W  = $clog2(BYTES + 1)
) (
    input  logic [31:0]       crc_in,
    input  logic [DATA_W-1:0] data,
    input  logic [CNT_W-1:0]  nbytes,
    output logic [31:0]       crc_out
);

    logic [31:0] crc;

    // NOTE: combinational blocks assign every variable before any branch so
    // no path leaves a value held, which would infer a latch.
    always_comb begin
        crc = crc_in;
        for (int i = 0; i < BYTES; i++) begin
            if (i < int'(nbytes)) begin
                crc = crc ^ {24'h0, data[DATA_W-1-8*i -: 8]};
                for (int b = 0; b < 8; b++) begin
                    crc = crc[0] ? ((crc >> 1) ^ LCRC_POLY) : (crc >> 1);
                end
            end
        end
        crc_out = crc;
    end

endmodule

// File: rtl/tlp_lcrc_framer.sv
// ---------------------------------------------------------------------------
// tlp_lcrc_framer
// Data Link Layer transmit framer for the replay path. Prepends the 16-bit
// sequence field to a streamed TLP, computes LCRC-32 on the fly and appends
// it, repacking the frame into full DATA_W beats (only the last is partial).
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_vld/in_rdy     input beat handshake
//   in_sop/in_eop     TLP delimiters (in_sop is informational only)
//   in_data           TLP bytes, byte 0 in the MSBs
//   in_dw             valid DWs in the eop beat
//   in_nullify        (LCRC_NULLIFY_EN only) invert LCRC of this TLP
//   out_vld/out_rdy   output beat handshake
//   out_sop/out_eop   frame delimiters
//   out_data          frame bytes, MSB-first
//   out_hw            valid halfwords in the beat, MSB-aligned
//   seq_ld/seq_ld_val load the sequence counter while idle
//   next_seq          sequence number of the next frame
//   busy              frame in flight
//
// Build option: define LCRC_NULLIFY_EN to add the in_nullify port.
// ---------------------------------------------------------------------------
module tlp_lcrc_framer
    import dll_pkg::*;
#(
    parameter  int DATA_W = 64,
    localparam int DW_W   = $clog2(DATA_W / 32) + 1,
    localparam int HW_W   = $clog2(DATA_W / 16) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DW_W-1:0]   in_dw,
`ifdef LCRC_NULLIFY_EN
    input  logic              in_nullify,
`endif
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              out_sop,
    output logic              out_eop,
    output logic [DATA_W-1:0] out_data,
    output logic [HW_W-1:0]   out_hw,
    input  logic              seq_ld,
    input  logic [SEQ_W-1:0]  seq_ld_val,
    output logic [SEQ_W-1:0]  next_seq,
    output logic              busy
);

    localparam int BYTES  = DATA_W / 8;
    localparam int HWS    = DATA_W / 16;
    localparam int WIDE_W = DATA_W + 48;
    localparam int NB_W   = $clog2(BYTES + 3);

    framer_state_t     state;
    logic [15:0]       carry;      // last two bytes of the previous input beat
    logic [31:0]       crc_reg;
    logic [47:0]       tail_buf;   // leftover bytes after the eop beat, MSB-first
    logic [2:0]        tail_hw;    // halfwords still held in tail_buf
    logic              nullify_q;

    logic              out_free, in_fire, out_fire, nullify_in;
    logic              first_beat;
    logic [15:0]       carry_eff;
    logic [31:0]       crc_cur, crc_step, lcrc;
    logic [DATA_W-1:0] data_masked;
    logic [NB_W-1:0]   step_nbytes;
    logic [WIDE_W-1:0] lcrc_vec, eop_wide, tail_wide;
    int                dw_n, eop_hw_tot, eop_hw, eop_left;
    int                tail_emit, tail_left;

    // in_sop carries no information the state machine needs.
    logic unused_in_sop;
    assign unused_in_sop = in_sop;

`ifdef LCRC_NULLIFY_EN
    assign nullify_in = in_nullify;
`else
    assign nullify_in = 1'b0;
`endif

    assign out_free = !out_vld || out_rdy;
    assign in_rdy   = !rst && (state != TAIL) && out_free;
    assign in_fire  = in_vld && in_rdy;
    assign out_fire = out_vld && out_rdy;

    // The first beat of a frame sees the sequence field in place of the carry
    // and starts from a fresh CRC.
    always_comb begin
        first_beat  = (state == IDLE);
        carry_eff   = first_beat ? {4'h0, next_seq} : carry;
        crc_cur     = first_beat ? LCRC_INIT : crc_reg;
        dw_n        = int'(in_dw);
        data_masked = in_data;
        step_nbytes = NB_W'(BYTES);
        if (in_eop) begin
            data_masked = in_data & ({DATA_W{1'b1}} << (DATA_W - 32 * dw_n));
            step_nbytes = NB_W'(2 + 4 * dw_n);
        end
    end

    // A mid-TLP beat folds the carry plus the top BYTES-2 data bytes (exactly
    // the output beat); the eop beat folds everything it still holds.
    lcrc32_step #(.DATA_W(DATA_W + 16)) u_step (
        .crc_in  (crc_cur),
        .data    ({carry_eff, data_masked}),
        .nbytes  (step_nbytes),
        .crc_out (crc_step)
    );

    // Eop beat: carry, valid TLP bytes and LCRC laid end to end in a
    // DATA_W+48 bit window; the top DATA_W go out now, the rest wait in TAIL.
    always_comb begin
        lcrc = crc_step ^ LCRC_XOROUT;
        if (nullify_in) begin
            lcrc = ~lcrc;
        end
        lcrc_vec   = {lcrc_byte_order(lcrc), {(DATA_W + 16){1'b0}}} >> (16 + 32 * dw_n);
        eop_wide   = {carry_eff, data_masked, 32'h0} | lcrc_vec;
        eop_hw_tot = 3 + 2 * dw_n;
        eop_hw     = (eop_hw_tot > HWS) ? HWS : eop_hw_tot;
        eop_left   = eop_hw_tot - eop_hw;
        tail_wide  = {tail_buf, {DATA_W{1'b0}}};
        tail_emit  = (int'(tail_hw) > HWS) ? HWS : int'(tail_hw);
        tail_left  = int'(tail_hw) - tail_emit;
    end

    // NOTE: registers are written with non-blocking assignments so every
    // read in this block sees the pre-edge value regardless of order.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: all control and datapath registers are reset; a partial frame
        // is simply abandoned.
        if (rst) begin
            state     <= IDLE;
            out_vld   <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= '0;
            out_hw    <= '0;
            next_seq  <= '0;
            busy      <= 1'b0;
            carry     <= '0;
            crc_reg   <= LCRC_INIT;
            tail_buf  <= '0;
            tail_hw   <= '0;
            nullify_q <= 1'b0;
        end else begin
            if (out_fire) begin
                out_vld <= 1'b0;
            end

            unique case (state)
                IDLE, BODY: begin
                    if (in_fire) begin
                        out_vld <= 1'b1;
                        out_sop <= (state == IDLE);
                        busy    <= 1'b1;
                        if (in_eop) begin
                            out_data  <= eop_wide[WIDE_W-1 -: DATA_W];
                            out_hw    <= HW_W'(eop_hw);
                            out_eop   <= (eop_left == 0);
                            tail_buf  <= eop_wide[47:0];
                            tail_hw   <= 3'(eop_left);
                            nullify_q <= nullify_in;
                            state     <= TAIL;
                        end else begin
                            out_data <= {carry_eff, in_data[DATA_W-1:16]};
                            out_hw   <= HW_W'(HWS);
                            out_eop  <= 1'b0;
                            carry    <= in_data[15:0];
                            crc_reg  <= crc_step;
                            state    <= BODY;
                        end
                    end else if (state == IDLE && seq_ld) begin
                        next_seq <= seq_ld_val;
                    end
                end

                TAIL: begin
                    if (tail_hw != 3'd0 && out_free) begin
                        out_vld  <= 1'b1;
                        out_sop  <= 1'b0;
                        out_data <= tail_wide[WIDE_W-1 -: DATA_W];
                        out_hw   <= HW_W'(tail_emit);
                        out_eop  <= (tail_left == 0);
                        tail_buf <= tail_wide[47:0];
                        tail_hw  <= 3'(tail_left);
                    end else if (out_fire && out_eop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!nullify_q) begin
                            next_seq <= next_seq + 12'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlp_lcrc_framer.sv
`timescale 1ns/1ps
module tb_tlp_lcrc_framer;

    localparam int DATA_W = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld, in_rdy, in_sop, in_eop;
    logic [63:0] in_data;
    logic [1:0]  in_dw;
    logic        in_nullify;
    logic        out_vld, out_rdy, out_sop, out_eop;
    logic [63:0] out_data;
    logic [2:0]  out_hw;
    logic        seq_ld;
    logic [11:0] seq_ld_val, next_seq;
    logic        busy;

    always #5 clk = ~clk;

    tlp_lcrc_framer #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_data    (in_data),
        .in_dw      (in_dw),
`ifdef LCRC_NULLIFY_EN
        .in_nullify (in_nullify),
`endif
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_data   (out_data),
        .out_hw     (out_hw),
        .seq_ld     (seq_ld),
        .seq_ld_val (seq_ld_val),
        .next_seq   (next_seq),
        .busy       (busy)
    );

    // Standalone CRC step for the "123456789" check value.
    logic [31:0] u_crc_in, u_crc_out;
    logic [71:0] u_data;
    logic [3:0]  u_nbytes;
    lcrc32_step #(.DATA_W(72)) u_step (
        .crc_in  (u_crc_in),
        .data    (u_data),
        .nbytes  (u_nbytes),
        .crc_out (u_crc_out)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  hw;
        logic        sop;
        logic        eop;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] tlp_dw[$];
    logic [7:0]  fbytes[$];
    logic [63:0] held;
    logic [31:0] lcrc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bit-serial reference CRC over fbytes.
    function automatic logic [31:0] crc_model();
        logic [31:0] c = 32'hFFFF_FFFF;
        logic        fb;
        foreach (fbytes[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ fbytes[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return c ^ 32'hFFFF_FFFF;
    endfunction

    task automatic build_bytes(input logic [11:0] seq);
        fbytes = {};
        fbytes.push_back({4'h0, seq[11:8]});
        fbytes.push_back(seq[7:0]);
        foreach (tlp_dw[i]) begin
            fbytes.push_back(tlp_dw[i][31:24]);
            fbytes.push_back(tlp_dw[i][23:16]);
            fbytes.push_back(tlp_dw[i][15:8]);
            fbytes.push_back(tlp_dw[i][7:0]);
        end
    endtask

    // Full expected frame from the byte-stream model, packed into 8-byte beats.
    task automatic push_frame(input logic [11:0] seq, input logic nul);
        logic [31:0] c;
        int n, nb, cnt;
        build_bytes(seq);
        c = crc_model();
        if (nul) c = ~c;
        fbytes.push_back(c[7:0]);
        fbytes.push_back(c[15:8]);
        fbytes.push_back(c[23:16]);
        fbytes.push_back(c[31:24]);
        n  = fbytes.size();
        nb = (n + 7) / 8;
        for (int i = 0; i < nb; i++) begin
            beat_t b;
            b.data = '0;
            cnt = 0;
            for (int j = 0; j < 8; j++) begin
                if (8 * i + j < n) begin
                    b.data[63-8*j -: 8] = fbytes[8*i+j];
                    cnt++;
                end
            end
            b.hw  = 3'(cnt / 2);
            b.sop = (i == 0);
            b.eop = (i == nb - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic push_beat(input logic [63:0] d, input logic [2:0] hw,
                             input logic sop, input logic eop);
        beat_t b;
        b.data = d; b.hw = hw; b.sop = sop; b.eop = eop;
        exp_q.push_back(b);
    endtask

    // Drives tlp_dw as a beat stream; starts and ends just after a rising edge.
    task automatic send_tlp(input logic nul);
        int n, nbeats, w;
        n      = tlp_dw.size();
        nbeats = (n + 1) / 2;
        for (int i = 0; i < nbeats; i++) begin
            in_data[63:32] = tlp_dw[2*i];
            in_data[31:0]  = 32'h0;
            if (2 * i + 1 < n) in_data[31:0] = tlp_dw[2*i+1];
            in_sop     = (i == 0);
            in_eop     = (i == nbeats - 1);
            in_dw      = (i == nbeats - 1) ? 2'(n - 2 * i) : 2'd2;
            in_nullify = nul;
            in_vld     = 1'b1;
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!in_rdy && w < 200);
            if (!in_rdy) begin
                checks++;
                errors++;
                $display("FAIL in_rdy_timeout: got 0 expected 1 (t=%0t)", $time);
            end
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_nullify = 1'b0;
    endtask

    task automatic load_seq(input logic [11:0] v);
        seq_ld = 1'b1;
        seq_ld_val = v;
        @(posedge clk);
        #1;
        seq_ld = 1'b0;
        check("seq_load", next_seq, v);
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((exp_q.size() != 0 || busy) && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_busy_low", busy, 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expected beat per output handshake.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", out_data, e.data);
                    check("beat_hw",   out_hw,   e.hw);
                    check("beat_sop",  out_sop,  e.sop);
                    check("beat_eop",  out_eop,  e.eop);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
        in_dw = 2'd1; in_nullify = 1'b0; out_rdy = 1'b1; seq_ld = 1'b0; seq_ld_val = '0;

        // Reset state
        #2;
        check("rst_in_rdy_low", in_rdy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_out_vld", out_vld, 0);
        check("rst_out_sop", out_sop, 0);
        check("rst_out_eop", out_eop, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_hw", out_hw, 0);
        check("rst_next_seq", next_seq, 0);
        check("rst_busy", busy, 0);
        check("idle_in_rdy", in_rdy, 1);

        // CRC step unit: "123456789" -> 0xCBF43926 after final XOR
        u_crc_in = 32'hFFFF_FFFF;
        u_data   = "123456789";
        u_nbytes = 4'd9;
        #1;
        check("step_check_value", u_crc_out ^ 32'hFFFF_FFFF, 32'hCBF4_3926);
        u_nbytes = 4'd0;
        #1;
        check("step_zero_bytes", u_crc_out, 32'hFFFF_FFFF);
        fbytes = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("model_check_value", crc_model(), 32'hCBF4_3926);
        @(posedge clk);
        #1;

        // Reference frame: seq 5, 12-byte TLP, hand-laid beats
        load_seq(12'h005);
        tlp_dw = '{32'h0011_2233, 32'h4455_6677, 32'h8899_AABB};
        build_bytes(12'h005);
        lcrc = crc_model();
        push_beat(64'h0005_0011_2233_4455, 3'd4, 1'b1, 1'b0);
        push_beat({48'h6677_8899_AABB, lcrc[7:0], lcrc[15:8]}, 3'd4, 1'b0, 1'b0);
        push_beat({lcrc[23:16], lcrc[31:24], 48'h0}, 3'd1, 1'b0, 1'b1);
        send_tlp(1'b0);
        wait_idle();
        check("ref_next_seq", next_seq, 12'h006);

`ifdef LCRC_NULLIFY_EN
        // Nullified reference frame: inverted LCRC, sequence not consumed
        load_seq(12'h005);
        push_beat(64'h0005_0011_2233_4455, 3'd4, 1'b1, 1'b0);
        push_beat({48'h6677_8899_AABB, ~lcrc[7:0], ~lcrc[15:8]}, 3'd4, 1'b0, 1'b0);
        push_beat({~lcrc[23:16], ~lcrc[31:24], 48'h0}, 3'd1, 1'b0, 1'b1);
        send_tlp(1'b1);
        wait_idle();
        check("nullify_next_seq", next_seq, 12'h005);
`endif

        // Sequence wrap with single-beat TLPs
        load_seq(12'hFFF);
        tlp_dw = '{32'hA1B2_C3D4};
        push_frame(12'hFFF, 1'b0);
        send_tlp(1'b0);
        check("busy_in_frame", busy, 1);
        wait_idle();
        check("wrap_next_seq_0", next_seq, 12'h000);
        tlp_dw = '{32'h5566_7788};
        push_frame(12'h000, 1'b0);
        send_tlp(1'b0);
        wait_idle();
        check("wrap_next_seq_1", next_seq, 12'h001);

        // Backpressure: same 7-DW frame unstalled, then with a 5-cycle stall
        tlp_dw = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10,
                   32'h1112_1314, 32'h1516_1718, 32'h191A_1B1C};
        load_seq(12'h123);
        push_frame(12'h123, 1'b0);
        send_tlp(1'b0);
        wait_idle();
        load_seq(12'h123);
        push_frame(12'h123, 1'b0);
        fork
            send_tlp(1'b0);
            begin
                @(posedge clk);
                #1;
                out_rdy = 1'b0;
                held = out_data;
                check("stall_out_vld", out_vld, 1);
                repeat (5) begin
                    @(negedge clk);
                    check("stall_data_held", out_data, held);
                    check("stall_in_rdy_low", in_rdy, 0);
                end
                @(posedge clk);
                #1;
                out_rdy = 1'b1;
            end
        join
        wait_idle();
        check("stall_next_seq", next_seq, 12'h124);

        // Reset while in BODY discards the frame
        out_rdy = 1'b0;
        in_data = 64'hDEAD_BEEF_0123_4567;
        in_sop = 1'b1; in_eop = 1'b0; in_dw = 2'd2; in_vld = 1'b1;
        @(negedge clk);
        check("body_in_rdy", in_rdy, 1);
        @(posedge clk);
        #1;
        in_vld = 1'b0; in_sop = 1'b0;
        check("body_out_vld", out_vld, 1);
        check("body_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_vld", out_vld, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_hw", out_hw, 0);
        check("midrst_out_eop", out_eop, 0);
        check("midrst_next_seq", next_seq, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_rdy", in_rdy, 0);
        @(posedge clk);
        #1;
        check("midrst_out_vld_edge", out_vld, 0);
        @(negedge clk);
        rst = 1'b0;
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        tlp_dw = '{32'hCAFE_F00D, 32'h1234_5678, 32'h9ABC_DEF0};
        push_frame(12'h000, 1'b0);
        send_tlp(1'b0);
        wait_idle();
        check("post_rst_next_seq", next_seq, 12'h001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlp_lcrc_framer.md
# tlp_lcrc_framer

Streaming Data Link Layer transmit framer for the replay path. It accepts a TLP as a multi-beat stream, prepends the 16-bit sequence field (4 reserved zero bits, then a 12-bit sequence number). It computes LCRC-32 incrementally over the sequence field and the TLP, appends the LCRC, and emits the repacked frame to the replay buffer. It supersedes the single-shot 96-bit CRC stage: it adds arbitrary TLP length, a parametrised datapath, sequence-number ownership and flow control.

## Interface
- `DATA_W`, 64: beat width in bits; a multiple of 32, at least 32.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_vld` input 1: input beat valid.
- `in_rdy` output 1: framer accepts the beat.
- `in_sop` input 1: first beat of a TLP.
- `in_eop` input 1: last beat of a TLP.
- `in_data` input DATA_W: TLP bytes, byte 0 in the MSBs.
- `in_dw` input clog2(DATA_W/32)+1: valid DWs in the eop beat, 1..DATA_W/32; ignored on other beats.
- `out_vld` output 1: output beat valid.
- `out_rdy` input 1: downstream accepts the beat.
- `out_sop` output 1: first beat of a frame.
- `out_eop` output 1: last beat of a frame.
- `out_data` output DATA_W: frame bytes, MSB-first.
- `out_hw` output clog2(DATA_W/16)+1: valid 16-bit halfwords in this beat, MSB-aligned.
- `seq_ld` input 1: load the sequence counter.
- `seq_ld_val` input 12: value to load.
- `next_seq` output 12: sequence number the next frame will carry.
- `busy` output 1: a frame is in flight.

## Operation
- Frame byte stream: {4'h0, seq[11:0]}, then TLP bytes, then LCRC[7:0], LCRC[15:8], LCRC[23:16], LCRC[31:24].
- The frame is packed into DATA_W beats. Every beat is full except the last. `out_hw` equals DATA_W/16 on non-last beats.
- Output beats per frame: ceil((4n+6)/(DATA_W/8)), where n is the TLP length in DWs.
- LCRC definition: reflected CRC-32, polynomial 0xEDB88320, initial value 0xFFFFFFFF, final XOR 0xFFFFFFFF. Each byte is processed LSB-first, in stream order, starting with the two sequence bytes.
- A 16-bit carry register holds the two-byte misalignment that the sequence prefix introduces.
- States:
  - IDLE: in_rdy=1. The first accepted beat starts a frame, whether or not in_sop is set; go to BODY, or to TAIL if in_eop is set.
  - BODY: in_sop is ignored. An accepted eop beat goes to TAIL.
  - TAIL: in_rdy=0. Emit the remaining carry and LCRC bytes over 1–2 beats. When out_eop is accepted, go to IDLE.
- The sequence number is captured at frame start. next_seq increments by 1 modulo 4096 when out_eop is accepted, so 0xFFF is followed by 0x000.
- seq_ld is honoured only in IDLE with no beat accepted in the same cycle; otherwise it is ignored. If seq_ld and a frame start coincide, the frame start wins.
- TLP length is unbounded; the LCRC is streamed.
- Reset values: out_vld=0, out_sop=0, out_eop=0, out_data=0, out_hw=0, next_seq=0, busy=0, state IDLE, CRC register 0xFFFFFFFF. in_rdy=0 while rst is asserted.
- Reset mid-frame discards the partial frame. No out_eop is produced.

## Timing
- A single output register, with in_rdy = (state≠TAIL) && (!out_vld || out_rdy).
- Latency is 1 cycle from input accept to the corresponding output beat. The first output beat appears 1 cycle after the sop beat is accepted.
- Throughput is 1 beat/cycle in BODY, plus 1–2 TAIL beats per frame.
- out_* stay stable while out_vld && !out_rdy.
- busy rises on the cycle after the frame starts and falls on the cycle after out_eop is accepted.

## Configuration
- `LCRC_NULLIFY_EN` defined: adds input `in_nullify`, sampled with the eop beat. When it is 1, the appended LCRC is the bitwise inverse of the normal LCRC, and next_seq does not increment.
- `LCRC_NULLIFY_EN` undefined: no such port exists, and every frame carries the normal LCRC.

## Structure
- Package `dll_pkg`:
  - LCRC_POLY, LCRC_INIT, LCRC_XOROUT.
  - SEQ_W=12.
  - Enum `framer_state_t` {IDLE, BODY, TAIL}.
- Sub-module `lcrc32_step`: combinational. It takes crc_in, DATA_W bits of data and a byte count, and produces crc_out.

## Test plan
- `lcrc32_step` unit: bytes "123456789", then final XOR -> 0xCBF43926.
- DATA_W=64, seq loaded to 5, TLP 0x0011223344556677 then 0x8899AABB (dw=1) -> three beats:
  - beat0 0x0005001122334455, hw=4, sop.
  - beat1 0x66778899AABB followed by the two low LCRC bytes, hw=4.
  - beat2 carries the two high LCRC bytes, hw=1, eop.
  - LCRC matches the model.
- Sequence wrap: seq_ld_val=0xFFF, two 1-DW TLPs -> prefixes 0x0FFF then 0x0000; next_seq=0x001 afterwards.
- Backpressure: out_rdy low for 5 cycles mid-frame -> out_data held stable, in_rdy low, frame bytes and LCRC identical to the unstalled run.
- Reset asserted in BODY -> outputs at reset values next edge. A following frame starts with seq 0x000 and a correct LCRC.
- Nullify, with LCRC_NULLIFY_EN: repeat the DATA_W=64 frame with in_nullify=1 -> LCRC is the ~ of the normal value, and next_seq is unchanged.
